reg_scoreboard: RTL

Tracks general-register writes that are in flight between the ID→EX handoff and WB register-file commit. Produces the ID-stage read-after-write stall. Sits beside the five-stage pipeline:
- fed by the ID issue handshake, the WB commit signals (rf_we/rf_waddr) and the pipeline flush;
- read by ID, which gates its ready_go with `stall`.

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/sb_counter.sv | 41 ++++
 rtl/reg_scoreboard.sv | 87 ++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register write scoreboard: address width,
// architectural register count and the hard-wired zero register.
package reg_scoreboard_pkg;

  localparam int SB_REG_AW = 5;
  localparam int SB_NREG   = 32;
  localparam logic [SB_REG_AW-1:0] SB_R0 = '0;

  // r0 is hard-wired to zero, so writes to it never need tracking.
  function automatic logic is_tracked(input logic [SB_REG_AW-1:0] addr);
    return addr != SB_R0;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One saturating up/down counter of outstanding writes to a single register.
// err_pulse flags an increment at full scale or a decrement at zero.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             err_pulse
);

  logic at_max;
  logic at_zero;
  logic inc_only;
  logic dec_only;

  always_comb begin
    at_max    = (cnt == '1);
    at_zero   = (cnt == '0);
    inc_only  = inc && !dec;
    dec_only  = dec && !inc;
    // A clear discards both events, so it can never produce an error.
    err_pulse = !clr && ((inc_only && at_max) || (dec_only && at_zero));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_only && !at_max) begin
      cnt <= cnt + 1'b1;
    end else if (dec_only && !at_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// In-flight register write scoreboard: counts issued-but-uncommitted writes
// per register and raises the ID-stage read-after-write stall.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG         = SB_NREG,
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2,
  parameter bit WB_BYPASS    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_fire,
  input  logic                 issue_we,
  input  logic [SB_REG_AW-1:0] issue_dest,
  input  logic                 wb_we,
  input  logic [SB_REG_AW-1:0] wb_dest,
  input  logic                 flush,
  input  logic                 rs1_valid,
  input  logic [SB_REG_AW-1:0] rs1,
  input  logic                 rs2_valid,
  input  logic [SB_REG_AW-1:0] rs2,
  input  logic                 id_we,
  input  logic [SB_REG_AW-1:0] id_dest,
  output logic                 stall,
  output logic                 busy,
  output logic                 err
);

  // Handshake: issue_fire is ID's valid && ready_go for the cycle the
  // instruction leaves ID; stall feeds ready_go and never looks at issue_fire,
  // which keeps the ready path free of combinational loops.
  logic inc_ev;
  logic dec_ev;
  logic rs1_hz;
  logic rs2_hz;
  logic ovf_hz;

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  err_vec;

  assign inc_ev = issue_fire && issue_we && is_tracked(issue_dest);
  assign dec_ev = wb_we && is_tracked(wb_dest);

  assign cnt[0]     = '0;
  assign err_vec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_ev && (issue_dest == SB_REG_AW'(r))),
      .dec       (dec_ev && (wb_dest == SB_REG_AW'(r))),
      .clr       (flush),
      .cnt       (cnt[r]),
      .err_pulse (err_vec[r])
    );
  end

  always_comb begin
    rs1_hz = rs1_valid && is_tracked(rs1) && (cnt[rs1] != '0);
    rs2_hz = rs2_valid && is_tracked(rs2) && (cnt[rs2] != '0);
    // With bypass, the last pending write committing now satisfies the read.
    if (WB_BYPASS) begin
      if ((cnt[rs1] == CNT_W'(1)) && wb_we && (wb_dest == rs1)) rs1_hz = 1'b0;
      if ((cnt[rs2] == CNT_W'(1)) && wb_we && (wb_dest == rs2)) rs2_hz = 1'b0;
    end
    ovf_hz = id_we && is_tracked(id_dest) && (cnt[id_dest] == CNT_W'(MAX_INFLIGHT));
    stall  = rs1_hz || rs2_hz || ovf_hz;
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      busy = busy || (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (|err_vec) begin
      err <= 1'b1;
    end
  end

endmodule
